// File: rtl/seven_segment_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seven_segment_capture_pkg
// Purpose : Shared definitions for the seven-segment capture block. It holds
//           the active-low segment patterns (bits a..g, MSB = a), the blank
//           pattern and its code, and the capture FSM state type.
// Ports   : none (package)
// Config  : none here; SEVSEG_DP_CAPTURE_EN is consumed by the top level.
// Revision: 1.0 - initial release
// ============================================================================
package seven_segment_capture_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0001100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seven_segment_decoder.sv
`default_nettype none
// ============================================================================
// Module  : seven_segment_decoder
// Purpose : Combinational decode of an active-low 7-bit segment pattern
//           (bit6 = a ... bit0 = g) into a 4-bit digit value. A fully dark
//           pattern decodes to the blank code and is legal; any pattern that
//           is not a digit or blank is flagged illegal.
// Ports   : pattern [6:0] in  - segment pattern, active low
//           value   [3:0] out - decoded digit, blank code when dark/illegal
//           legal         out - high when pattern is a digit or blank
// Revision: 1.0 - initial release
// ============================================================================
module seven_segment_decoder
  import seven_segment_capture_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       legal
);

  always_comb begin
    value = BLANK_CODE;
    legal = 1'b1;
    case (pattern)
      SEG_0:     value = 4'd0;
      SEG_1:     value = 4'd1;
      SEG_2:     value = 4'd2;
      SEG_3:     value = 4'd3;
      SEG_4:     value = 4'd4;
      SEG_5:     value = 4'd5;
      SEG_6:     value = 4'd6;
      SEG_7:     value = 4'd7;
      SEG_8:     value = 4'd8;
      SEG_9:     value = 4'd9;
      SEG_BLANK: value = BLANK_CODE;
      default:   legal = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seven_segment_capture.sv
`default_nettype none
// ============================================================================
// Module  : seven_segment_capture
// Purpose : Snoops a multiplexed, active-low seven-segment display bus and
//           captures the value shown on each digit once the segment/anode
//           bus has been stable for STABLE_CYCLES synchronized samples.
// Ports   : i_clk                     in  - clock, rising edge
//           i_rst                     in  - asynchronous active-high reset
//           i_segments  [7:0]         in  - segments a..g (bit7..bit1), dp bit0
//           i_anodes    [NUM_DIGITS]  in  - active-low digit enables
//           i_clr_error               in  - clears the sticky error flag
//           o_digits    [4*NUM_DIGITS] out - captured value, digit n at [4n+:4]
//           o_valid     [NUM_DIGITS]  out - digit n captured since reset
//           o_update                  out - one-cycle strobe on each capture
//           o_error                   out - sticky: illegal pattern or
//                                           persistent anode conflict
//           o_dp        [NUM_DIGITS]  out - captured decimal point (only with
//                                           SEVSEG_DP_CAPTURE_EN)
// Config  : define SEVSEG_DP_CAPTURE_EN to capture the decimal point and
//           include it in the stability comparison.
// Revision: 1.0 - initial release
// ============================================================================
module seven_segment_capture
  import seven_segment_capture_pkg::*;
#(
  parameter int NUM_DIGITS    = 3,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [7:0]              i_segments,
  input  logic [NUM_DIGITS-1:0]   i_anodes,
  input  logic                    i_clr_error,
  output logic [4*NUM_DIGITS-1:0] o_digits,
  output logic [NUM_DIGITS-1:0]   o_valid,
  output logic                    o_update,
`ifdef SEVSEG_DP_CAPTURE_EN
  output logic [NUM_DIGITS-1:0]   o_dp,
`endif
  output logic                    o_error
);

`ifdef SEVSEG_DP_CAPTURE_EN
  localparam logic [7:0] CMP_MASK = 8'hFF;
`else
  localparam logic [7:0] CMP_MASK = 8'hFE;  // dp bit ignored
`endif
  localparam logic [7:0] STABLE_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] CONF_THRESH = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] CNT_SAT     = 8'hFF;

  logic [7:0]            seg_meta, seg_sync, prev_seg;
  logic [NUM_DIGITS-1:0] an_meta, an_sync, prev_an;
  state_t                state;
  logic [7:0]            count;
  logic [7:0]            conflict_count;

  logic       an_idle, an_single, an_conflict, changed, commit;
  logic       dec_legal, error_set;
  logic [3:0] dec_value;

  // Anode classification of the current synchronized sample.
  assign an_idle     = &an_sync;
  assign an_single   = $onehot(~an_sync);
  assign an_conflict = !an_idle && !an_single;

  assign changed = (((seg_sync ^ prev_seg) & CMP_MASK) != 8'h00) || (an_sync != prev_an);

  // Commit happens the cycle after the window fills; prev_* then holds the
  // pattern that was stable for the whole window.
  assign commit = (state == ST_TRACK) && (count == STABLE_MAX);

  assign error_set = (commit && !dec_legal) || (an_conflict && (conflict_count >= CONF_THRESH));

  seven_segment_decoder u_decoder (
    .pattern (prev_seg[7:1]),
    .value   (dec_value),
    .legal   (dec_legal)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      seg_meta       <= '1;
      seg_sync       <= '1;
      an_meta        <= '1;
      an_sync        <= '1;
      prev_seg       <= '1;
      prev_an        <= '1;
      state          <= ST_IDLE;
      count          <= 8'd0;
      conflict_count <= 8'd0;
      o_digits       <= {NUM_DIGITS{BLANK_CODE}};
      o_valid        <= '0;
      o_update       <= 1'b0;
      o_error        <= 1'b0;
`ifdef SEVSEG_DP_CAPTURE_EN
      o_dp           <= '0;
`endif
    end else begin
      seg_meta <= i_segments;
      seg_sync <= seg_meta;
      an_meta  <= i_anodes;
      an_sync  <= an_meta;
      prev_seg <= seg_sync;
      prev_an  <= an_sync;
      o_update <= 1'b0;

      if (an_conflict) begin
        if (conflict_count != CNT_SAT) conflict_count <= conflict_count + 8'd1;
      end else begin
        conflict_count <= 8'd0;
      end

      // Set has priority over clear.
      if (error_set)        o_error <= 1'b1;
      else if (i_clr_error) o_error <= 1'b0;

      case (state)
        ST_IDLE: begin
          count <= 8'd0;
          if (an_single) begin
            state <= ST_TRACK;
            count <= 8'd1;
          end
        end

        ST_TRACK: begin
          if (commit) begin
            if (dec_legal) begin
              for (int n = 0; n < NUM_DIGITS; n++) begin
                if (!prev_an[n]) begin
                  o_digits[4*n +: 4] <= dec_value;
                  o_valid[n]         <= 1'b1;
`ifdef SEVSEG_DP_CAPTURE_EN
                  o_dp[n]            <= ~prev_seg[0];
`endif
                end
              end
              o_update <= 1'b1;
            end
            // A change arriving on the commit cycle must not be lost in HOLD.
            if (!an_single) begin
              state <= ST_IDLE;
              count <= 8'd0;
            end else if (changed) begin
              count <= 8'd1;
            end else begin
              state <= ST_HOLD;
            end
          end else if (!an_single) begin
            state <= ST_IDLE;
            count <= 8'd0;
          end else if (changed) begin
            count <= 8'd1;
          end else if (count != CNT_SAT) begin
            count <= count + 8'd1;
          end
        end

        ST_HOLD: begin
          if (!an_single) begin
            state <= ST_IDLE;
            count <= 8'd0;
          end else if (changed) begin
            state <= ST_TRACK;
            count <= 8'd1;
          end
        end

        default: begin
          state <= ST_IDLE;
          count <= 8'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_capture.sv
`default_nettype none
// ============================================================================
// Module  : tb_seven_segment_capture
// Purpose : Self-checking bench for seven_segment_capture (NUM_DIGITS=3,
//           STABLE_CYCLES=8). Stimulus pushes expected captures into a
//           scoreboard queue; a monitor pops and compares on every o_update.
// Config  : honours SEVSEG_DP_CAPTURE_EN (connects and checks o_dp).
// Revision: 1.0 - initial release
// ============================================================================
module tb_seven_segment_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  segments = 8'hFF;
  logic [2:0]  anodes = 3'b111;
  logic        clr_error = 1'b0;
  logic [11:0] digits;
  logic [2:0]  valid;
  logic        update;
  logic        error;
`ifdef SEVSEG_DP_CAPTURE_EN
  logic [2:0]  dp;
`endif

  seven_segment_capture #(
    .NUM_DIGITS    (3),
    .STABLE_CYCLES (8)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_segments  (segments),
    .i_anodes    (anodes),
    .i_clr_error (clr_error),
    .o_digits    (digits),
    .o_valid     (valid),
    .o_update    (update),
`ifdef SEVSEG_DP_CAPTURE_EN
    .o_dp        (dp),
`endif
    .o_error     (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] digits;
    logic [2:0]  valid;
    logic [2:0]  dp;
    int          at;   // required cycle of the strobe, -1 = any
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, logic [31:0] actual, logic [31:0] required);
    n_checks++;
    if (actual !== required) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  // Scoreboard monitor: every capture strobe must match the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && update) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_update: o_update=1 at cycle %0d, required 0", cyc);
      end else begin
        e = sb.pop_front();
        check("upd_digits", 32'(digits), 32'(e.digits));
        check("upd_valid", 32'(valid), 32'(e.valid));
        if (e.at >= 0) check("upd_cycle", 32'(cyc), 32'(e.at));
`ifdef SEVSEG_DP_CAPTURE_EN
        check("upd_dp", 32'(dp), 32'(e.dp));
`endif
      end
    end
  end

  task automatic drive(logic [7:0] s, logic [2:0] a, int n);
    segments = s;
    anodes   = a;
    repeat (n) @(negedge clk);
  endtask

  task automatic push(logic [11:0] d, logic [2:0] v, logic [2:0] p, int at);
    exp_t e;
    e.digits = d;
    e.valid  = v;
    e.dp     = p;
    e.at     = at;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    segments = 8'hFF;
    anodes = 3'b111;
    clr_error = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_digits", 32'(digits), 32'h0000_0FFF);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_update", 32'(update), 32'h0);
    check("rst_error", 32'(error), 32'h0);
`ifdef SEVSEG_DP_CAPTURE_EN
    check("rst_dp", 32'(dp), 32'h0);
`endif
    rst = 1'b0;
  endtask

  logic [7:0]  pats [3] = '{8'b1001_1111, 8'b0010_0101, 8'b0000_1101};
  logic [2:0]  ans  [3] = '{3'b110, 3'b101, 3'b011};
  logic [11:0] exd  [3] = '{12'hFF1, 12'hF21, 12'h321};
  logic [2:0]  exv  [3] = '{3'b001, 3'b011, 3'b111};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] seg7;
    logic [2:0] dp7;
    @(negedge clk);
    do_reset();

    // Digit 0 on anode 0: capture exactly 11 cycles after the inputs change.
    push(12'hFF0, 3'b001, 3'b000, cyc + 11);
    drive(8'b0000_0011, 3'b110, 20);
    check("t1_digits", 32'(digits), 32'h0000_0FF0);
    check("t1_valid", 32'(valid), 32'h1);
    drive(8'hFF, 3'b111, 4);

    // Round-robin scan of 1,2,3 twice; three captures per scan.
    for (int scan = 0; scan < 2; scan++) begin
      for (int d = 0; d < 3; d++) begin
        if (scan == 0) push(exd[d], exv[d], 3'b000, -1);
        else           push(12'h321, 3'b111, 3'b000, -1);
        drive(pats[d], ans[d], 16);
      end
    end
    drive(8'hFF, 3'b111, 4);
    check("t2_digits", 32'(digits), 32'h0000_0321);
    check("t2_valid", 32'(valid), 32'h7);
    check("t2_sb_empty", 32'(sb.size()), 32'h0);

    // Segments never stable long enough: no capture at all.
    do_reset();
    for (int i = 0; i < 6; i++)
      drive((i % 2) ? 8'b0000_0001 : 8'b0000_0011, 3'b110, 4);
    drive(8'hFF, 3'b111, 4);
    check("t3_valid", 32'(valid), 32'h0);
    check("t3_digits", 32'(digits), 32'h0000_0FFF);
    check("t3_error", 32'(error), 32'h0);

    // Anode conflict: error set after exactly 8 conflicting samples.
    drive(8'b0000_0011, 3'b100, 9);
    check("t4_err_before", 32'(error), 32'h0);
    drive(8'b0000_0011, 3'b100, 1);
    check("t4_err_set", 32'(error), 32'h1);
    drive(8'hFF, 3'b111, 3);
    check("t4_err_sticky", 32'(error), 32'h1);
    check("t4_digits", 32'(digits), 32'h0000_0FFF);
    clr_error = 1'b1;
    @(negedge clk);
    clr_error = 1'b0;
    check("t4_err_clr", 32'(error), 32'h0);

    // Illegal pattern on digit 1.
    drive(8'b1010_1011, 3'b101, 20);
    check("t5_error", 32'(error), 32'h1);
    check("t5_digit1", 32'(digits[7:4]), 32'hF);
    check("t5_valid1", 32'(valid[1]), 32'h0);
    drive(8'hFF, 3'b111, 4);

    // Reset mid-window (counter at 5) while showing 7.
`ifdef SEVSEG_DP_CAPTURE_EN
    seg7 = 8'b0001_1110;
    dp7  = 3'b001;
`else
    seg7 = 8'b0001_1111;
    dp7  = 3'b000;
`endif
    drive(seg7, 3'b110, 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_error", 32'(error), 32'h0);
    push(12'hFF7, 3'b001, dp7, cyc + 11);
    drive(seg7, 3'b110, 20);
    check("t6_digits", 32'(digits), 32'h0000_0FF7);
    drive(8'hFF, 3'b111, 4);

    check("final_sb_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seven_segment_capture.md
SEVEN_SEGMENT_CAPTURE -- requirements
Module: seven_segment_capture

Interface
REQ-001 Parameter NUM_DIGITS, default 3, number of multiplexed digit positions monitored (legal 1..8).
REQ-002 Parameter STABLE_CYCLES, default 8, consecutive identical synchronized samples required to commit a digit (legal 2..255).
REQ-003 i_clk  input  1  sole clock; all state on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_segments  input  8  active-low segment bus, bit7=a … bit1=g, bit0=dp; asynchronous to i_clk.
REQ-006 i_anodes  input  NUM_DIGITS  active-low digit enables, bit n selects digit n; asynchronous to i_clk.
REQ-007 i_clr_error  input  1  synchronous clear of o_error.
REQ-008 o_digits  output  4*NUM_DIGITS  decoded value per digit, digit n at [4n+3:4n].
REQ-009 o_valid  output  NUM_DIGITS  bit n high once digit n has been committed at least once since reset.
REQ-010 o_update  output  1  one-cycle strobe coincident with any o_digits/o_valid change.
REQ-011 o_error  output  1  sticky error flag.

Function
REQ-012 i_segments and i_anodes each pass through a two-flop synchronizer; "sample" below means the second-stage value.
REQ-013 Decode of segment bits [7:1]: 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0001100->9, 1111111->4'hF (blank); any other pattern is illegal.
REQ-014 Selected digit is legal only when exactly one anode sample bit is low; none low = idle, more than one low = conflict.
REQ-015 FSM states IDLE, TRACK, HOLD; reset state IDLE.
REQ-016 IDLE: stability counter held 0; on a legal single-anode sample go to TRACK with counter = 1.
REQ-017 TRACK: sample identical to previous sample (all 8 segment bits and all anode bits) increments counter; any difference reloads counter to 1 and stays TRACK; anodes idle or conflicting go to IDLE.
REQ-018 TRACK: when counter reaches STABLE_CYCLES, commit: legal pattern writes decoded value to digit n, sets o_valid[n], pulses o_update on the following cycle with registers already updated; illegal pattern sets o_error and leaves digit n unchanged; either way go to HOLD.
REQ-019 HOLD: no further commits while sample is unchanged; any change goes to TRACK with counter = 1 (or IDLE if anodes idle/conflicting).
REQ-020 Conflicting anodes for STABLE_CYCLES consecutive samples set o_error.
REQ-021 o_error clears on i_clr_error; if set and clear occur in the same cycle, set wins.
REQ-022 Input-to-output latency for a stable pattern: 2 (sync) + STABLE_CYCLES + 1 cycles.
REQ-023 Counter saturates; it never wraps.

Reset
REQ-024 During i_rst: o_digits all 4'hF, o_valid 0, o_update 0, o_error 0, synchronizers all ones, FSM IDLE, counter 0.
REQ-025 Reset asserted mid-TRACK discards the partial window; no commit or o_update follows reset release until a full new window completes.

Configuration
REQ-026 Macro SEVSEG_DP_CAPTURE_EN defined: output o_dp [NUM_DIGITS-1:0] added, o_dp[n] = inverted dp bit committed with digit n, reset 0, and the dp bit participates in stability comparison.
REQ-027 Macro undefined: no o_dp port, dp bit excluded from stability comparison and decode.

Structure
REQ-028 Shared package holds the ten segment pattern constants, the blank pattern, the blank code 4'hF, and the FSM state type.
REQ-029 Sub-module seven_segment_decoder: combinational 7-bit pattern -> 4-bit value plus legal flag.

Verification
REQ-030 Reset, anodes=3'b110, segments=8'b0000_0011 held 20 cycles -> o_digits[3:0]=0, o_valid=3'b001, single o_update at cycle 11 after first sample.
REQ-031 Round-robin anodes 110/101/011 each 16 cycles with digits 1,2,3 -> o_digits=12'h321, o_valid=3'b111, exactly 3 o_update pulses per scan.
REQ-032 Segments toggle 0/8 patterns every 4 cycles on anode 110 -> no commit, o_update never pulses, o_valid=0.
REQ-033 anodes=3'b100 held 10 cycles -> o_error=1, o_digits unchanged; i_clr_error pulse -> o_error=0.
REQ-034 Illegal pattern 8'b1010_1011 stable on anode 101 -> o_error=1, digit1 stays 4'hF, o_valid[1]=0.
REQ-035 i_rst pulsed at counter=5 during stable digit 7 -> no o_update until 8 new stable samples after release; with SEVSEG_DP_CAPTURE_EN, segments 8'b0001_1110 -> digit 7, o_dp[n]=1.
